// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the non-forwarding 5-stage core.
// Shadows EX/MEM/WB destinations and resolves RAW hazards seen by ID.
module hazard_stall_ctrl #(
   parameter int P_RF_BYPASS = 1,
   parameter int P_CNT_W     = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_id_valid,
   input  logic [4:0]         i_id_rs1_addr,
   input  logic               i_id_rs1_used,
   input  logic [4:0]         i_id_rs2_addr,
   input  logic               i_id_rs2_used,
   input  logic [4:0]         i_id_rd_addr,
   input  logic               i_id_rd_wren,
   input  logic               i_ex_br_taken,
   output logic               o_pc_en,
   output logic               o_if_id_en,
   output logic               o_if_id_flush,
   output logic               o_id_ex_bubble,
   output logic               o_stall,
   output logic [P_CNT_W-1:0] o_stall_cnt,
   output logic [P_CNT_W-1:0] o_flush_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
   } slot_t;

   slot_t ex_q;
   slot_t mem_q;
   slot_t wb_q;
   slot_t ex_d;

   logic m1;
   logic m2;
   logic raw;
   logic issue;

   always_comb begin
      m1 = (ex_q.valid  && ex_q.rd  == i_id_rs1_addr) ||
           (mem_q.valid && mem_q.rd == i_id_rs1_addr);
      m2 = (ex_q.valid  && ex_q.rd  == i_id_rs2_addr) ||
           (mem_q.valid && mem_q.rd == i_id_rs2_addr);
      // Without write-then-read in the RF, WB is still a hazard.
      if (P_RF_BYPASS == 0) begin
         m1 = m1 || (wb_q.valid && wb_q.rd == i_id_rs1_addr);
         m2 = m2 || (wb_q.valid && wb_q.rd == i_id_rs2_addr);
      end
      raw = i_id_valid &&
            ((i_id_rs1_used && i_id_rs1_addr != 5'd0 && m1) ||
             (i_id_rs2_used && i_id_rs2_addr != 5'd0 && m2));
   end

   always_comb begin
      o_stall        = raw && !i_ex_br_taken;
      o_pc_en        = !o_stall;
      o_if_id_en     = !o_stall;
      o_if_id_flush  = i_ex_br_taken;
      o_id_ex_bubble = o_stall || i_ex_br_taken;
      issue = i_id_valid && i_id_rd_wren && i_id_rd_addr != 5'd0 &&
              !o_stall && !i_ex_br_taken;
      ex_d  = issue ? slot_t'{1'b1, i_id_rd_addr} : slot_t'{1'b0, 5'd0};
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         wb_q  <= mem_q;
         mem_q <= ex_q;
         ex_q  <= ex_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_stall_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (o_stall && o_stall_cnt != '1)
            o_stall_cnt <= o_stall_cnt + P_CNT_W'(1);
         if (i_ex_br_taken && o_flush_cnt != '1)
            o_flush_cnt <= o_flush_cnt + P_CNT_W'(1);
      end
   end

endmodule
